// File: rtl/dram_block_controller.sv
// Block-granular DRAM model behind the data cache: fixed access latency, then a
// one-word-per-cycle burst into a word-wide backing store, completed by a mem_ready pulse.
module dram_block_controller #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int MEM_WORDS   = 16384,
  parameter int LATENCY     = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          mem_valid,
  input  logic                          mem_rw,
  input  logic [ADDR_W-1:0]             mem_address,
  input  logic [WORD_W*BLOCK_WORDS-1:0] mem_wdata,
  output logic [WORD_W*BLOCK_WORDS-1:0] mem_rdata,
  output logic                          mem_ready,
  output logic                          busy
);

  // state | meaning
  // IDLE  | no request in flight
  // WAIT  | access latency, lat_cnt counting down to 0
  // BURST | one word moved per cycle at block base + beat
  // DONE  | mem_ready high; a new request may be accepted here
  localparam int BW = $clog2(BLOCK_WORDS);
  localparam int MW = $clog2(MEM_WORDS);
  localparam int OB = BW + 2;
  localparam int LW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t              state;
  logic                rw_q;
  logic [MW-BW-1:0]    blk_q;
  logic [LW-1:0]       lat_cnt;
  logic [BW-1:0]       beat;
  logic [WORD_W-1:0]   wbuf  [BLOCK_WORDS];
  logic [WORD_W-1:0]   store [MEM_WORDS];
  logic [MW-1:0]       word_idx;
  logic                accept;
  logic                unused_addr;

  // Block base is aligned, so base+beat is just the beat in the low index bits;
  // address bits above the store depth wrap away.
  assign word_idx    = {blk_q, beat};
  assign accept      = mem_valid && (state == IDLE || state == DONE);
  assign unused_addr = ^mem_address;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      mem_rdata <= '0;
      lat_cnt   <= '0;
      beat      <= '0;
      rw_q      <= 1'b0;
      blk_q     <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (mem_valid) begin
            state   <= WAIT;
            busy    <= 1'b1;
            rw_q    <= mem_rw;
            blk_q   <= mem_address[MW+1:OB];
            lat_cnt <= LW'(LATENCY - 1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state <= BURST;
            beat  <= '0;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        BURST: begin
          if (!rw_q)
            mem_rdata[int'(beat)*WORD_W +: WORD_W] <= store[word_idx];
          beat <= beat + BW'(1);
          if (beat == BW'(BLOCK_WORDS - 1)) begin
            state     <= DONE;
            mem_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write line is captured whole at accept so the cache may change mem_wdata afterwards.
  always_ff @(posedge clock) begin
    if (!reset && accept && mem_rw)
      for (int i = 0; i < BLOCK_WORDS; i++)
        wbuf[i] <= mem_wdata[i*WORD_W +: WORD_W];
  end

  // Backing store is never cleared; a reset only stops further beats.
  always_ff @(posedge clock) begin
    if (!reset && state == BURST && rw_q)
      store[word_idx] <= wbuf[beat];
  end

endmodule
